// File: rtl/conv_layer_sched_if.sv
// Layer datapath and feature-map RAM write port seen by the layer sequencer.
// master: sequencer side; slave: layer datapath / RAM side.
interface conv_layer_sched_if #(
    parameter int CNT_W = 16
);
    logic             layer_rst;
    logic             layer_start;
    logic             layer_done;
    logic             layer_out_valid;
    logic [31:0]      layer_out_data;
    logic             wr_en;
    logic             wr_bank;
    logic             rd_bank;
    logic [CNT_W-1:0] wr_addr;
    logic [7:0]       wr_data;

    modport master (
        output layer_rst, layer_start, wr_en, wr_bank, rd_bank, wr_addr, wr_data,
        input  layer_done, layer_out_valid, layer_out_data
    );

    modport slave (
        input  layer_rst, layer_start, wr_en, wr_bank, rd_bank, wr_addr, wr_data,
        output layer_done, layer_out_valid, layer_out_data
    );
endinterface

// File: rtl/conv_layer_sched.sv
// Sequences the conv layers, captures each layer's output stream into the
// ping-pong feature RAM with 8-bit saturation, and flags timeout/count faults.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | waiting for run
//  S_LRST   | layer_rst asserted for one cycle
//  S_LSTART | layer_start pulse, counters cleared
//  S_RUN    | capturing pixels, watchdog running
//  S_CHECK  | compare pixel count with the layer's expected size
//  S_FINISH | done pulse, then back to idle
//  S_ERR    | sticky fault, layer held in reset until run or abort
module conv_layer_sched #(
    parameter int                          NUM_LAYERS = 3,
    parameter int                          CNT_W      = 16,
    parameter logic [NUM_LAYERS*CNT_W-1:0] OUT_COUNTS = {16'd2048, 16'd4096, 16'd16384},
    parameter int                          TIMEOUT    = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               run,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               error,
    output logic [1:0]         err_code,
    output logic [1:0]         layer_idx,
    conv_layer_sched_if.master lyr
);
    localparam int             WD_W     = $clog2(TIMEOUT + 1);
    // Fault when the increment would bring the watchdog to TIMEOUT-1.
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 2);
    localparam logic [1:0]     LAST_IDX = 2'(NUM_LAYERS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LRST, S_LSTART, S_RUN, S_CHECK, S_FINISH, S_ERR
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] pix_cnt;
    logic [CNT_W-1:0] exp_cnt;
    logic [WD_W-1:0]  wd;
    logic             layer_rst_q;
    logic             layer_start_q;
    logic             wr_en_q;
    logic [CNT_W-1:0] wr_addr_q;
    logic [7:0]       wr_data_q;
    logic [7:0]       pix_sat;

    always_comb begin
        exp_cnt = '0;
        for (int i = 0; i < NUM_LAYERS; i++)
            if (layer_idx == 2'(i)) exp_cnt = OUT_COUNTS[i*CNT_W +: CNT_W];
    end

    always_comb begin
        if (lyr.layer_out_data[31])         pix_sat = 8'd0;
        else if (|lyr.layer_out_data[30:8]) pix_sat = 8'hff;
        else                                pix_sat = lyr.layer_out_data[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            error         <= 1'b0;
            err_code      <= 2'd0;
            layer_idx     <= 2'd0;
            layer_rst_q   <= 1'b1;
            layer_start_q <= 1'b0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 8'd0;
            pix_cnt       <= '0;
            wd            <= '0;
        end else begin
            done          <= 1'b0;
            layer_start_q <= 1'b0;
            wr_en_q       <= 1'b0;
            layer_rst_q   <= 1'b0;
            if (abort) begin
                state       <= S_IDLE;
                busy        <= 1'b0;
                error       <= 1'b0;
                err_code    <= 2'd0;
                layer_rst_q <= 1'b1;
            end else begin
                case (state)
                    S_IDLE, S_ERR: begin
                        layer_rst_q <= (state == S_ERR) || run;
                        if (run) begin
                            state     <= S_LRST;
                            layer_idx <= 2'd0;
                            error     <= 1'b0;
                            err_code  <= 2'd0;
                            busy      <= 1'b1;
                        end
                    end
                    S_LRST: begin
                        state         <= S_LSTART;
                        layer_start_q <= 1'b1;
                    end
                    S_LSTART: begin
                        state   <= S_RUN;
                        pix_cnt <= '0;
                        wd      <= '0;
                    end
                    S_RUN: begin
                        if (lyr.layer_out_valid && pix_cnt == exp_cnt) begin
                            state       <= S_ERR;
                            error       <= 1'b1;
                            err_code    <= 2'd2;
                            busy        <= 1'b0;
                            layer_rst_q <= 1'b1;
                        end else begin
                            if (lyr.layer_out_valid) begin
                                wr_en_q   <= 1'b1;
                                wr_addr_q <= pix_cnt;
                                wr_data_q <= pix_sat;
                                pix_cnt   <= pix_cnt + 1'b1;
                                wd        <= '0;
                            end
                            if (lyr.layer_done) begin
                                state <= S_CHECK;
                            end else if (!lyr.layer_out_valid) begin
                                if (wd == WD_LAST) begin
                                    state       <= S_ERR;
                                    error       <= 1'b1;
                                    err_code    <= 2'd1;
                                    busy        <= 1'b0;
                                    layer_rst_q <= 1'b1;
                                end else begin
                                    wd <= wd + 1'b1;
                                end
                            end
                        end
                    end
                    S_CHECK: begin
                        if (pix_cnt != exp_cnt) begin
                            state       <= S_ERR;
                            error       <= 1'b1;
                            err_code    <= 2'd3;
                            busy        <= 1'b0;
                            layer_rst_q <= 1'b1;
                        end else if (layer_idx == LAST_IDX) begin
                            state <= S_FINISH;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state       <= S_LRST;
                            layer_idx   <= layer_idx + 2'd1;
                            layer_rst_q <= 1'b1;
                        end
                    end
                    S_FINISH: state <= S_IDLE;
                    default:  state <= S_IDLE;
                endcase
            end
        end
    end

    assign lyr.layer_rst   = layer_rst_q;
    assign lyr.layer_start = layer_start_q;
    assign lyr.wr_en       = wr_en_q;
    assign lyr.wr_addr     = wr_addr_q;
    assign lyr.wr_data     = wr_data_q;
    assign lyr.wr_bank     = layer_idx[0];
    assign lyr.rd_bank     = ~layer_idx[0];
endmodule

// File: tb/tb_conv_layer_sched.sv
// Directed bench for conv_layer_sched: two layers of 6 and 4 pixels, TIMEOUT 16,
// with a write scoreboard fed from a pixel-level model of the layer stream.
module tb_conv_layer_sched;
    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       abort = 1'b0;
    logic       busy, done, error;
    logic [1:0] err_code, layer_idx;

    conv_layer_sched_if #(.CNT_W(CNT_W)) lyr ();

    conv_layer_sched #(
        .NUM_LAYERS (2),
        .CNT_W      (CNT_W),
        .OUT_COUNTS ({16'd4, 16'd6}),
        .TIMEOUT    (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .abort     (abort),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .err_code  (err_code),
        .layer_idx (layer_idx),
        .lyr       (lyr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        bank;
        logic [15:0] addr;
        logic [7:0]  data;
    } wr_t;

    int   layer_size[2] = '{6, 4};
    wr_t  exp_q[$];
    int   wr_log[$];
    int   pix_q[$];
    int   wr_count = 0;
    int   total = 0;
    int   passed = 0;
    wr_t  cur;

    function automatic int sat_m(input int v);
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Scoreboard: every write the DUT issues must be the next one the model predicted.
    always @(negedge clk) begin
        if (rst_n && lyr.wr_en) begin
            wr_count++;
            wr_log.push_back(int'(lyr.wr_data));
            chk("write_expected", int'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
                chk("wr_bank", int'(lyr.wr_bank), int'(cur.bank));
                chk("rd_bank", int'(lyr.rd_bank), int'(!cur.bank));
                chk("wr_addr", int'(lyr.wr_addr), int'(cur.addr));
                chk("wr_data", int'(lyr.wr_data), int'(cur.data));
            end
        end
    end

    // Run pulse, then expect LRST next cycle and layer_start the cycle after; ends in RUN.
    task automatic kick();
        run = 1'b1;
        step();
        run = 1'b0;
        chk("run_busy", int'(busy), 1);
        chk("run_layer_rst", int'(lyr.layer_rst), 1);
        chk("run_layer_idx", int'(layer_idx), 0);
        chk("run_error_cleared", int'(error), 0);
        step();
        chk("lstart_pulse", int'(lyr.layer_start), 1);
        chk("lstart_rst_low", int'(lyr.layer_rst), 0);
        step();
    endtask

    // Drive pix_q as back-to-back valids; pixels beyond the layer size must not be written.
    task automatic emit(input int layer, input bit done_with_last);
        for (int i = 0; i < pix_q.size(); i++) begin
            lyr.layer_out_valid = 1'b1;
            lyr.layer_out_data  = pix_q[i];
            if (done_with_last && i == pix_q.size() - 1) lyr.layer_done = 1'b1;
            if (i < layer_size[layer])
                exp_q.push_back('{bank: layer[0], addr: 16'(i), data: 8'(sat_m(pix_q[i]))});
            step();
        end
        lyr.layer_out_valid = 1'b0;
        lyr.layer_out_data  = '0;
        lyr.layer_done      = 1'b0;
    endtask

    task automatic next_layer(input int idx);
        lyr.layer_done = 1'b1;
        step();
        lyr.layer_done = 1'b0;
        chk("check_no_start", int'(lyr.layer_start), 0);
        step();
        chk("next_layer_rst", int'(lyr.layer_rst), 1);
        chk("next_layer_idx", int'(layer_idx), idx);
        step();
        chk("next_layer_start", int'(lyr.layer_start), 1);
        step();
    endtask

    task automatic clean_run();
        int c0;
        int base;
        c0 = wr_count;
        kick();
        pix_q = '{-20, 30, 80, 130, 180, 230};
        emit(0, 1'b0);
        next_layer(1);
        base = wr_log.size();
        pix_q = '{300, -5, 128, 7};
        emit(1, 1'b1);
        chk("check_done_low", int'(done), 0);
        step();
        chk("done_pulse", int'(done), 1);
        chk("finish_busy", int'(busy), 0);
        chk("finish_error", int'(error), 0);
        step();
        chk("done_one_cycle", int'(done), 0);
        chk("write_count", wr_count - c0, 10);
        chk("sat_300", wr_log[base], 255);
        chk("sat_neg5", wr_log[base + 1], 0);
        chk("sat_128", wr_log[base + 2], 128);
    endtask

    initial begin
        lyr.layer_done      = 1'b0;
        lyr.layer_out_valid = 1'b0;
        lyr.layer_out_data  = '0;
        step();
        step();
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_err_code", int'(err_code), 0);
        chk("rst_layer_idx", int'(layer_idx), 0);
        chk("rst_layer_rst", int'(lyr.layer_rst), 1);
        chk("rst_layer_start", int'(lyr.layer_start), 0);
        chk("rst_wr_en", int'(lyr.wr_en), 0);
        chk("rst_wr_addr", int'(lyr.wr_addr), 0);
        chk("rst_wr_data", int'(lyr.wr_data), 0);
        rst_n = 1'b1;
        step();
        chk("idle_layer_rst_low", int'(lyr.layer_rst), 0);

        clean_run();

        // Count short: layer 0 delivers 5 of 6 pixels.
        kick();
        pix_q = '{10, 20, 30, 40, 50};
        emit(0, 1'b0);
        lyr.layer_done = 1'b1;
        step();
        lyr.layer_done = 1'b0;
        step();
        chk("short_err_code", int'(err_code), 3);
        chk("short_error", int'(error), 1);
        chk("short_busy", int'(busy), 0);
        chk("short_layer_rst", int'(lyr.layer_rst), 1);
        step();
        step();
        chk("err_sticky", int'(error), 1);
        chk("err_layer_rst_held", int'(lyr.layer_rst), 1);

        // Overflow: layer 1 expects 4 but emits 5.
        kick();
        pix_q = '{1, 2, 3, 4, 5, 6};
        emit(0, 1'b0);
        next_layer(1);
        pix_q = '{400, 41, 42, 43, 44};
        emit(1, 1'b0);
        chk("ovf_err_code", int'(err_code), 2);
        chk("ovf_error", int'(error), 1);
        chk("ovf_wr_suppressed", int'(lyr.wr_en), 0);
        chk("ovf_busy", int'(busy), 0);

        // Timeout: no pixels after layer_start.
        kick();
        for (int i = 2; i <= 16; i++) begin
            step();
            if (i == 15) chk("timeout_not_early", int'(err_code), 0);
        end
        chk("timeout_err_code", int'(err_code), 1);
        chk("timeout_error", int'(error), 1);
        chk("timeout_busy", int'(busy), 0);

        // Abort in RUN with valid and done in the same cycle.
        kick();
        pix_q = '{11, 22};
        emit(0, 1'b0);
        lyr.layer_out_valid = 1'b1;
        lyr.layer_out_data  = 99;
        lyr.layer_done      = 1'b1;
        abort               = 1'b1;
        step();
        abort               = 1'b0;
        lyr.layer_out_valid = 1'b0;
        lyr.layer_out_data  = '0;
        lyr.layer_done      = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_wr_en", int'(lyr.wr_en), 0);
        chk("abort_layer_rst", int'(lyr.layer_rst), 1);
        chk("abort_error", int'(error), 0);
        chk("abort_start", int'(lyr.layer_start), 0);
        step();
        chk("abort_rst_pulse_end", int'(lyr.layer_rst), 0);
        chk("abort_no_write", int'(lyr.wr_en), 0);

        clean_run();

        step();
        chk("pending_writes", exp_q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach the summary");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/conv_layer_sched.md
# conv_layer_sched

Sequencer for the fixed-point CIFAR-10 inference chain. It runs up to NUM_LAYERS conv layers one after another. For each layer it resets the layer, pulses its start and captures the layer's one-pixel-per-valid output stream into a ping-pong feature-map RAM, saturating each pixel to 8 bits. It checks each layer's output count against its configured size, guards against stalled layers with a watchdog, and reports completion or a sticky error to the top level.

## Interface
Parameters:
- NUM_LAYERS, 3: number of layers sequenced, 1..4.
- CNT_W, 16: width of pixel counter, write address and per-layer count fields.
- OUT_COUNTS, {16'd2048,16'd4096,16'd16384}: packed expected outputs per layer; layer 0 in bits [CNT_W-1:0].
- TIMEOUT, 4096: max cycles allowed between layer start or last valid and the next valid or done.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous, active-low reset.
- run  in  1  start-sequence pulse; sampled only in IDLE or ERR.
- abort  in  1  return to IDLE from any state.
- busy  out  1  high from the cycle after an accepted run until FINISH/ERR/abort.
- done  out  1  one-cycle pulse when all layers complete cleanly.
- error  out  1  sticky fault flag; cleared by run, abort or reset.
- err_code  out  2  0 none, 1 timeout, 2 overflow, 3 count short.
- layer_idx  out  2  index of the active layer.
- layer_rst  out  1  active-high reset to the muxed layer datapath.
- layer_start  out  1  one-cycle start pulse to the active layer.
- layer_done  in  1  active layer done (level; stays high until layer_rst).
- layer_out_valid  in  1  active layer pixel strobe.
- layer_out_data  in  32  active layer pixel, signed.
- wr_en  out  1  feature-RAM write strobe.
- wr_bank  out  1  bank written, equal to layer_idx[0].
- rd_bank  out  1  bank the active layer reads, equal to ~layer_idx[0].
- wr_addr  out  CNT_W  write address.
- wr_data  out  8  saturated pixel.

## Operation
- States: IDLE, LRST, LSTART, RUN, CHECK, FINISH, ERR.
- IDLE:
  - run → layer_idx=0, clear error/err_code, busy=1, go to LRST.
- LRST: layer_rst=1 for exactly one cycle → LSTART.
- LSTART:
  - layer_start=1 for one cycle.
  - Pixel counter=0, watchdog=0 → RUN.
- RUN, on each cycle with layer_out_valid:
  - Register a write: wr_en=1, wr_addr=counter, wr_data=sat(layer_out_data).
  - Increment counter and reload watchdog.
- RUN, overflow: if counter already equals OUT_COUNTS[layer_idx] when a valid arrives, suppress the write and go to ERR with code 2.
- RUN, layer_done=1 → CHECK. A valid in the same cycle as done is captured first.
- RUN, timeout: watchdog reaching TIMEOUT-1 with no valid and no done → ERR with code 1.
- CHECK:
  - counter ≠ expected → ERR with code 3.
  - Else, if last layer → FINISH.
  - Else layer_idx+1 → LRST.
- FINISH: done=1 for one cycle, busy=0 → IDLE.
- ERR:
  - error=1 and busy=0; layer_rst held at 1.
  - run → restart the sequence as from IDLE.
- abort, any state:
  - Next state IDLE, busy=0.
  - layer_rst=1 for one cycle; any pending wr_en is dropped.
  - error cleared.
- Saturation: negative → 0; >255 → 255; else data[7:0].
- run while busy is ignored. abort takes priority over all other events, including run in the same cycle.

## Timing
- Reset values: busy=0, done=0, error=0, err_code=0, layer_idx=0, layer_rst=1, layer_start=0, wr_en=0, wr_addr=0, wr_data=0; state IDLE. Outside LRST/ERR/abort, layer_rst returns to 0.
- run to layer_rst: 1 cycle. layer_start follows 1 cycle later.
- layer_out_valid at cycle t → wr_en/wr_addr/wr_data at t+1. Back-to-back valids give back-to-back writes.
- Sampled layer_done → CHECK next cycle.
- Between layers: CHECK → LRST → LSTART, i.e. 3 cycles from done to the next layer_start.
- Reset mid-operation: immediate return to reset values. No writes are issued after reset deassertion until a new run.

## Test plan
- Clean run, NUM_LAYERS=2, OUT_COUNTS={4,6}; model emits 6 then 4 valids and asserts done:
  - 10 writes; addresses 0..5 in bank 0, then 0..3 in bank 1.
  - done pulse 1 cycle after the last CHECK; error=0.
- Saturation: data 300, −5, 128 → wr_data 255, 0, 128.
- Count short: expected 6, model emits 5 then done → error=1, err_code=3, busy=0, layer_rst=1.
- Overflow: expected 4, model emits 5 valids → the 5th write is suppressed; err_code=2.
- Timeout, TIMEOUT=16: no valids after layer_start → err_code=1 exactly 16 cycles after layer_start.
- abort mid-RUN, with valid and done asserted in the same cycle: next cycle IDLE, no wr_en, layer_rst pulse; a subsequent run completes cleanly.
